wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage_pkg.sv | 14 +
 rtl/load_align.sv | 55 +++++
 rtl/wb_stage.sv | 105 ++++++++++
 tb/tb_wb_stage.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// rtl/wb_stage_pkg.sv - shared load-type encodings and register constants for wb_stage
package wb_stage_pkg;

  // Load kinds carried in in_ld_type; codes 101-111 behave as a word load
  localparam logic [2:0] LD_W  = 3'b000;
  localparam logic [2:0] LD_B  = 3'b001;
  localparam logic [2:0] LD_BU = 3'b010;
  localparam logic [2:0] LD_H  = 3'b011;
  localparam logic [2:0] LD_HU = 3'b100;

  // Hard-wired zero register; writes to it are never issued
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - combinational load extractor: lane select, extension, misalignment flag
module load_align
  import wb_stage_pkg::*;
(
  input  logic [31:0] i_mem_data,
  input  logic [2:0]  i_ld_type,
  input  logic [1:0]  i_byte_off,
  output logic [31:0] o_data,
  output logic        o_misal
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Little-endian byte lane picked by the low address bits
  always_comb begin
    w_byte = i_mem_data[7:0];
    case (i_byte_off)
      2'd0: w_byte = i_mem_data[7:0];
      2'd1: w_byte = i_mem_data[15:8];
      2'd2: w_byte = i_mem_data[23:16];
      2'd3: w_byte = i_mem_data[31:24];
      default: w_byte = i_mem_data[7:0];
    endcase
  end

  assign w_half = i_byte_off[1] ? i_mem_data[31:16] : i_mem_data[15:0];

  // Extend the selected lane and flag accesses that straddle their natural alignment
  always_comb begin
    o_data  = i_mem_data;
    o_misal = 1'b0;
    case (i_ld_type)
      LD_B: begin
        o_data = {{24{w_byte[7]}}, w_byte};
      end
      LD_BU: begin
        o_data = {24'd0, w_byte};
      end
      LD_H: begin
        o_data  = {{16{w_half[15]}}, w_half};
        o_misal = i_byte_off[0];
      end
      LD_HU: begin
        o_data  = {16'd0, w_half};
        o_misal = i_byte_off[0];
      end
      default: begin
        o_data  = i_mem_data;
        o_misal = (i_byte_off != 2'd0);
      end
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - one-entry write-back stage with forwarding; optional macro WB_RETIRE_CNT_EN adds retire_cnt
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wen,
  input  logic [4:0]        in_waddr,
  input  logic              in_is_load,
  input  logic [DATA_W-1:0] in_alu_res,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [2:0]        in_ld_type,
  input  logic [1:0]        in_byte_off,
  input  logic              hold,
  input  logic              flush,
  output logic              we,
  output logic [4:0]        wAddr,
  output logic [DATA_W-1:0] wData,
  output logic              fwd_valid,
  output logic [4:0]        fwd_addr,
  output logic [DATA_W-1:0] fwd_data,
  output logic              misalign
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]       retire_cnt
`endif
);

  logic              r_valid;
  logic              r_wen;
  logic              r_misal;
  logic [4:0]        r_waddr;
  logic [DATA_W-1:0] r_data;

  logic [DATA_W-1:0] w_ld_data;
  logic              w_ld_misal;
  logic [DATA_W-1:0] w_result;
  logic              w_misal_in;
  logic              w_accept;
  logic              w_retire;
  logic              w_wr_ok;

  load_align u_load_align (
    .i_mem_data (in_mem_data),
    .i_ld_type  (in_ld_type),
    .i_byte_off (in_byte_off),
    .o_data     (w_ld_data),
    .o_misal    (w_ld_misal)
  );

  // The result is resolved at capture so the held entry drives outputs directly
  assign w_result   = in_is_load ? w_ld_data : in_alu_res;
  assign w_misal_in = in_is_load && w_ld_misal;

  assign in_ready = !r_valid || !hold;
  assign w_accept = in_valid && in_ready;
  // A flushed entry never retires, so it produces neither a write nor a misalign pulse
  assign w_retire = r_valid && !hold && !flush;
  assign w_wr_ok  = r_wen && (r_waddr != REG_ZERO) && !r_misal;

  assign we        = w_retire && w_wr_ok;
  assign wAddr     = r_waddr;
  assign wData     = r_data;
  assign misalign  = w_retire && r_misal;
  assign fwd_valid = r_valid && w_wr_ok;
  assign fwd_addr  = r_waddr;
  assign fwd_data  = r_data;

  // Pipeline register: flush wins over capture, capture may coincide with retire
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_wen   <= 1'b0;
      r_misal <= 1'b0;
      r_waddr <= '0;
      r_data  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_wen   <= in_wen;
      r_misal <= w_misal_in;
      r_waddr <= in_waddr;
      r_data  <= w_result;
    end else if (w_retire) begin
      r_valid <= 1'b0;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  // Count every retire, misaligned ones included; wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt <= '0;
    end else if (w_retire) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - scoreboard bench for wb_stage with directed and random stimulus
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_wen;
  logic [4:0]  in_waddr;
  logic        in_is_load;
  logic [31:0] in_alu_res;
  logic [31:0] in_mem_data;
  logic [2:0]  in_ld_type;
  logic [1:0]  in_byte_off;
  logic        hold;
  logic        flush;
  logic        we;
  logic [4:0]  wAddr;
  logic [31:0] wData;
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
  logic        misalign;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  wb_stage #(.DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_wen      (in_wen),
    .in_waddr    (in_waddr),
    .in_is_load  (in_is_load),
    .in_alu_res  (in_alu_res),
    .in_mem_data (in_mem_data),
    .in_ld_type  (in_ld_type),
    .in_byte_off (in_byte_off),
    .hold        (hold),
    .flush       (flush),
    .we          (we),
    .wAddr       (wAddr),
    .wData       (wData),
    .fwd_valid   (fwd_valid),
    .fwd_addr    (fwd_addr),
    .fwd_data    (fwd_data),
    .misalign    (misalign)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_cnt  (retire_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_wr;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference view of the held instruction
  bit          cur_valid;
  bit          cur_fwd;
  bit          cur_obs;
  logic [4:0]  cur_addr;
  logic [31:0] cur_data;
  int unsigned exp_cnt;

  // Output snapshot taken mid-cycle by each step
  logic        s_we, s_mis, s_fwd, s_rdy;
  logic [4:0]  s_addr;
  logic [31:0] s_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Load semantics from the ISA rules: pick lane by shifting, then extend
  function automatic logic [32:0] ref_load(input logic [31:0] mem, input logic [2:0] lt,
                                           input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] hw;
    logic [31:0] d;
    logic        m;
    b  = 8'(mem >> (8 * off));
    hw = 16'(mem >> (16 * off[1]));
    m  = 1'b0;
    case (lt)
      3'd1: d = 32'($signed(b));
      3'd2: d = 32'(b);
      3'd3: begin d = 32'($signed(hw)); m = off[0]; end
      3'd4: begin d = 32'(hw); m = off[0]; end
      default: begin d = mem; m = (off != 2'd0); end
    endcase
    return {m, d};
  endfunction

  // One clock of stimulus; expected observable events go to the scoreboard
  task automatic step(input logic v, input logic wen, input logic [4:0] wa, input logic isl,
                      input logic [31:0] alu, input logic [31:0] mem, input logic [2:0] lt,
                      input logic [1:0] off, input logic h, input logic f);
    logic [32:0] lr;
    logic [31:0] res;
    bit          mis, accept, retire, obs, fw;
    exp_t        e;
    @(negedge clk);
    in_valid = v; in_wen = wen; in_waddr = wa; in_is_load = isl;
    in_alu_res = alu; in_mem_data = mem; in_ld_type = lt; in_byte_off = off;
    hold = h; flush = f;
    lr     = ref_load(mem, lt, off);
    res    = isl ? lr[31:0] : alu;
    mis    = isl && lr[32];
    fw     = wen && (wa != 5'd0) && !mis;
    obs    = fw || mis;
    accept = v && (!cur_valid || !h);
    retire = cur_valid && !h && !f;
    if (f && cur_valid && cur_obs) void'(exp_q.pop_back());
    if (accept && !f && obs) begin
      e.is_wr = !mis; e.addr = wa; e.data = res;
      exp_q.push_back(e);
    end
    if (retire) exp_cnt++;
    #2;
    s_we = we; s_mis = misalign; s_fwd = fwd_valid; s_rdy = in_ready;
    s_addr = wAddr; s_data = wData;
    chk("in_ready", in_ready, (!cur_valid || !h));
    chk("fwd_valid", fwd_valid, (cur_valid && cur_fwd));
    if (cur_valid && cur_fwd) begin
      chk("fwd_addr", fwd_addr, cur_addr);
      chk("fwd_data", fwd_data, cur_data);
    end
    if (f) cur_valid = 0;
    else if (accept) begin
      cur_valid = 1; cur_fwd = fw; cur_obs = obs; cur_addr = wa; cur_data = res;
    end else if (retire) cur_valid = 0;
  endtask

  task automatic idle();
    step(0, 0, 5'd0, 0, 32'd0, 32'd0, 3'd0, 2'd0, 0, 0);
  endtask

  task automatic alu_op(input logic [4:0] wa, input logic [31:0] alu);
    step(1, 1, wa, 0, alu, 32'hDEAD_BEEF, 3'd0, 2'd0, 0, 0);
  endtask

  task automatic do_reset(input logic h);
    @(negedge clk);
    rst = 1; in_valid = 0; hold = h; flush = 0;
    #2;
    chk("rst_we", we, 0);
    chk("rst_wAddr", wAddr, 0);
    chk("rst_wData", wData, 0);
    chk("rst_fwd_valid", fwd_valid, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_in_ready", in_ready, 1);
`ifdef WB_RETIRE_CNT_EN
    chk("rst_retire_cnt", retire_cnt, 0);
`endif
    exp_q.delete();
    cur_valid = 0; exp_cnt = 0;
    @(negedge clk);
    rst = 0; hold = 0;
  endtask

  // Monitor: every write or misalign pulse must match the oldest expected event
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!rst) begin
        if (we) begin
          if (exp_q.size() == 0) chk("unexpected_we", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("we_kind", 1, e.is_wr);
            chk("wAddr", wAddr, e.addr);
            chk("wData", wData, e.data);
          end
        end
        if (misalign) begin
          if (exp_q.size() == 0) chk("unexpected_misalign", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("misalign_kind", 0, e.is_wr);
          end
        end
      end
    end
  end

  initial begin
    rst = 1; in_valid = 0; in_wen = 0; in_waddr = 0; in_is_load = 0;
    in_alu_res = 0; in_mem_data = 0; in_ld_type = 0; in_byte_off = 0;
    hold = 0; flush = 0;
    cur_valid = 0; cur_fwd = 0; cur_obs = 0; cur_addr = 0; cur_data = 0; exp_cnt = 0;

    do_reset(0);

    // Plain ALU write, visible the cycle after acceptance
    alu_op(5'd5, 32'h1234);
    idle();
    chk("alu_we", s_we, 1);
    chk("alu_wAddr", s_addr, 5);
    chk("alu_wData", s_data, 32'h0000_1234);

    // Byte and halfword extraction on 0x80FF7F01
    step(1, 1, 5'd3, 1, 32'd0, 32'h80FF_7F01, 3'd1, 2'd3, 0, 0);
    step(1, 1, 5'd4, 1, 32'd0, 32'h80FF_7F01, 3'd2, 2'd3, 0, 0);
    chk("lb_wData", s_data, 32'hFFFF_FF80);
    step(1, 1, 5'd6, 1, 32'd0, 32'h80FF_7F01, 3'd3, 2'd2, 0, 0);
    chk("lbu_wData", s_data, 32'h0000_0080);
    idle();
    chk("lh_wData", s_data, 32'hFFFF_80FF);

    // Destination $0 is never written nor forwarded
    alu_op(5'd0, 32'h5555);
    idle();
    chk("r0_we", s_we, 0);
    chk("r0_fwd", s_fwd, 0);

    // Held entry stays put for three cycles, then writes once
    alu_op(5'd7, 32'h77);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 5'd8, 0, 32'h88, 32'd0, 3'd0, 2'd0, 1, 0);
      chk("hold_we", s_we, 0);
      chk("hold_ready", s_rdy, 0);
      chk("hold_fwd", s_fwd, 1);
    end
    alu_op(5'd8, 32'h88);
    chk("hold_release_we", s_we, 1);
    chk("hold_release_addr", s_addr, 7);
    idle();
    chk("after_hold_addr", s_addr, 8);

    // Misaligned word load: no write, one-cycle misalign pulse
    step(1, 1, 5'd9, 1, 32'd0, 32'h1122_3344, 3'd0, 2'd1, 0, 0);
    idle();
    chk("mis_we", s_we, 0);
    chk("mis_pulse", s_mis, 1);
    idle();
    chk("mis_pulse_end", s_mis, 0);
`ifdef WB_RETIRE_CNT_EN
    chk("mis_retire_cnt", retire_cnt, exp_cnt);
`endif

    // Flush coincident with a new input discards both
    alu_op(5'd10, 32'hA);
    step(1, 1, 5'd11, 0, 32'hB, 32'd0, 3'd0, 2'd0, 0, 1);
    chk("flush_we", s_we, 0);
    chk("flush_mis", s_mis, 0);
    idle();
    chk("after_flush_we", s_we, 0);

    // Back-to-back inputs: one write per cycle
    for (int i = 0; i < 4; i++) begin
      alu_op(5'(13 + i), 32'(100 + i));
      if (i > 0) chk("b2b_we", s_we, 1);
    end
    idle();
    chk("b2b_last_we", s_we, 1);
    idle();
`ifdef WB_RETIRE_CNT_EN
    chk("b2b_retire_cnt", retire_cnt, exp_cnt);
`endif

    // Reset while holding discards the entry
    alu_op(5'd12, 32'hC);
    step(0, 0, 5'd0, 0, 32'd0, 32'd0, 3'd0, 2'd0, 1, 0);
    chk("pre_rst_fwd", s_fwd, 1);
    do_reset(1);
    idle();
    chk("post_rst_we", s_we, 0);
    idle();

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
           $urandom_range(0, 1) == 1, $urandom, $urandom, 3'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0);
    end
    for (int i = 0; i < 3; i++) idle();
    chk("queue_drained", exp_q.size(), 0);
`ifdef WB_RETIRE_CNT_EN
    chk("final_retire_cnt", retire_cnt, exp_cnt);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
